// File: rtl/max7219_frame_tx.sv
// -----------------------------------------------------------------------------
// max7219_frame_tx
//
// Serial transmitter for a cascade of MAX7219 LED drivers. A parallel frame of
// 16 bits per device is shifted out MSB first on a divided serial clock. LOAD
// is then pulsed high so that every chip in the chain latches its word.
//
// Frame layout: i_data[16*G_NB_DEVICES-1 -: 16] is the word for the device
// farthest from the transmitter. Each word is {4'hx, addr[3:0], data[7:0]}.
//
// Serial timing: each bit gets G_CLK_DIV cycles with the serial clock low and
// then G_CLK_DIV cycles with it high. DIN changes only when a low phase starts,
// so it is stable around the rising edge at which the device samples it.
//
// Optional feature: define MAX7219_TX_OVERRUN_EN to add the o_overrun output.
// It gives a registered one-cycle pulse after any cycle in which i_start was
// asserted while the transmitter was busy. Without the macro, such requests are
// dropped silently and the port does not exist.
//
// All pin-facing outputs are registered. They are decoded from the next-state
// values so they change exactly on the state transitions, with no
// combinational glitches reaching the display.
// -----------------------------------------------------------------------------
module max7219_frame_tx #(
    parameter int G_NB_DEVICES  = 1,
    parameter int G_CLK_DIV     = 4,
    parameter int G_LOAD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [16*G_NB_DEVICES-1:0] i_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_max7219_clk,
    output logic                      o_max7219_data,
    output logic                      o_max7219_load
`ifdef MAX7219_TX_OVERRUN_EN
    ,
    output logic                      o_overrun
`endif
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int FRAME_W = 16 * G_NB_DEVICES;

    // The bit counter runs from FRAME_W-1 down to 0.
    localparam int BIT_MAX = FRAME_W - 1;
    localparam int BIT_W   = (BIT_MAX < 1) ? 1 : $clog2(BIT_MAX + 1);

    // The phase counter times both the serial half-periods and the LOAD pulse,
    // so it is sized for the longer of the two.
    localparam int PH_MAX = ((G_CLK_DIV > G_LOAD_CYCLES) ? G_CLK_DIV : G_LOAD_CYCLES) - 1;
    localparam int PH_W   = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(G_CLK_DIV - 1);
    localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(G_LOAD_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_MAX);
    localparam logic [PH_W-1:0]  PH_ZERO   = '0;
    localparam logic [BIT_W-1:0] BIT_ZERO  = '0;

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SHIFT_LOW  = 3'd1;
    localparam logic [2:0] ST_SHIFT_HIGH = 3'd2;
    localparam logic [2:0] ST_LOAD       = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [2:0]         state,     state_nxt;
    logic [PH_W-1:0]    ph_cnt,    ph_cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt,   bit_cnt_nxt;
    logic [FRAME_W-1:0] shift_reg, shift_reg_nxt;

    // Phase counter helpers. The counter is reloaded explicitly at every phase
    // boundary, so it never relies on wrapping.
    logic div_end;
    logic load_end;
    logic ph_step_nxt;

    assign div_end  = (ph_cnt == DIV_LAST);
    assign load_end = (ph_cnt == LOAD_LAST);

    // Next-state logic: sequencing of serial phases, bit shifting and LOAD.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (which would infer a latch).
        state_nxt     = state;
        ph_cnt_nxt    = ph_cnt;
        bit_cnt_nxt   = bit_cnt;
        shift_reg_nxt = shift_reg;
        ph_step_nxt   = 1'b0;

        case (state)
            // IDLE and DONE both accept a new frame. Accepting in DONE lets
            // frames run back to back with no dead cycle.
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    shift_reg_nxt = i_data;
                    bit_cnt_nxt   = BIT_LAST;
                    ph_cnt_nxt    = PH_ZERO;
                    state_nxt     = ST_SHIFT_LOW;
                end else begin
                    state_nxt     = ST_IDLE;
                end
            end

            ST_SHIFT_LOW: begin
                if (div_end) begin
                    ph_cnt_nxt = PH_ZERO;
                    state_nxt  = ST_SHIFT_HIGH;
                end else begin
                    ph_step_nxt = 1'b1;
                end
            end

            // The next bit is exposed only when the following low phase
            // starts. After the last bit nothing shifts, so DIN keeps the final
            // bit through LOAD and into IDLE.
            ST_SHIFT_HIGH: begin
                if (div_end) begin
                    ph_cnt_nxt = PH_ZERO;
                    if (bit_cnt == BIT_ZERO) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        shift_reg_nxt = {shift_reg[FRAME_W-2:0], 1'b0};
                        bit_cnt_nxt   = bit_cnt - 1'b1;
                        state_nxt     = ST_SHIFT_LOW;
                    end
                end else begin
                    ph_step_nxt = 1'b1;
                end
            end

            ST_LOAD: begin
                if (load_end) begin
                    ph_cnt_nxt = PH_ZERO;
                    state_nxt  = ST_DONE;
                end else begin
                    ph_step_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                ph_cnt_nxt = PH_ZERO;
            end
        endcase

        if (ph_step_nxt) begin
            ph_cnt_nxt = ph_cnt + 1'b1;
        end
    end

    // State, counters and shift register, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            ph_cnt    <= ph_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_reg_nxt;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_max7219_clk  <= 1'b0;
            o_max7219_data <= 1'b0;
            o_max7219_load <= 1'b0;
        end else begin
            o_busy         <= (state_nxt == ST_SHIFT_LOW) ||
                              (state_nxt == ST_SHIFT_HIGH) ||
                              (state_nxt == ST_LOAD);
            o_done         <= (state_nxt == ST_DONE);
            o_max7219_clk  <= (state_nxt == ST_SHIFT_HIGH);
            o_max7219_data <= shift_reg_nxt[FRAME_W-1];
            o_max7219_load <= (state_nxt == ST_LOAD);
        end
    end

`ifdef MAX7219_TX_OVERRUN_EN
    // Flag any request made while a frame is in flight. The flag comes one
    // cycle later and does not disturb the current frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= i_start && o_busy;
        end
    end
`endif

endmodule
